refill_arbiter: RTL and testbench
=================================

// Module: refill_arbiter
// PURPOSE
//  Sequences and shares the single SPI flash controller between L1I and L1D refills.
//  Takes icache/dcache miss requests and grants one refill at a time, alternating when both pend.
//  Issues one SPI read per grant, returns data with a one-cycle fetch pulse, and drives the core stall.
//  Sits between icache/dcache and spi_controller inside the memory subsystem.
// PARAMETERS
//  ADDR_W   20    flash byte address width (1MB address space)
//  DATA_W   32    refill word width
//  TIMEOUT  4096  max cycles in WAIT for spi_data_ready before abort (>=2)
// PORTS
//  CLK_CPU         in   1       CPU clock; all state on posedge
//  RST_N           in   1       asynchronous reset, active low
//  icache_miss     in   1       L1I miss, level, held until serviced
//  icache_addr     in   ADDR_W  L1I miss address (nextPC[19:0])
//  dcache_miss     in   1       L1D miss, level, held until serviced
//  dcache_addr     in   ADDR_W  L1D miss address (mem_addr[19:0])
//  spi_req         out  1       one-cycle start pulse to SPI controller
//  spi_addr        out  ADDR_W  flash address; stable from ISSUE through WAIT
//  spi_data_ready  in   1       one-cycle pulse: spi_data valid
//  spi_data        in   DATA_W  read word from flash
//  icache_fetch    out  1       one-cycle write strobe to L1I
//  dcache_fetch    out  1       one-cycle write strobe to L1D
//  refill_data     out  DATA_W  registered refill word, valid while a fetch is high
//  stall           out  1       pipeline stall
//  timeout_err     out  1       sticky: an SPI read timed out
//  err_clr         in   1       clears timeout_err
// BEHAVIOUR
//  Reset (RST_N=0, async): state=IDLE, last_grant=I, timer=0. All outputs 0: spi_req, spi_addr,
//   fetches, refill_data, timeout_err. stall is combinational (= misses while in IDLE).
//   Reset mid-transaction aborts immediately. No fetch is issued. SPI controller shares RST_N.
//  FSM IDLE->ISSUE->WAIT->DONE->IDLE:
//   IDLE: if any miss, latch grant+addr. Both pending -> grant the one != last_grant.
//    After reset, last_grant=I, so D wins first. Update last_grant on grant. No miss -> stay.
//   ISSUE: spi_req=1 for exactly this cycle. spi_addr=latched addr. -> WAIT, timer=0.
//   WAIT: on spi_data_ready, register refill_data<=spi_data. -> DONE.
//    Otherwise timer++. If timer==TIMEOUT-1 with no ready: set timeout_err, mark aborted, -> DONE.
//   DONE: pulse the granted fetch for 1 cycle if not aborted and that miss is still high.
//    A dropped miss (flush) means data is discarded. -> IDLE.
//  spi_data_ready outside WAIT is ignored.
//  Latency: miss seen in IDLE at cycle t -> spi_req at t+1. Ready at cycle w -> fetch at w+1.
//   Minimum miss-to-fetch = 3 cycles + SPI latency.
//  stall = icache_miss | dcache_miss | (state!=IDLE).
//  Timer width $clog2(TIMEOUT). It saturates; it never wraps.
//  err_clr and a new timeout in the same cycle -> timeout_err stays 1 (set wins).
//  Aborted refill: the miss stays high, so it is re-arbitrated in IDLE. Retry counts as a grant.
//  At most one fetch strobe is high in any cycle. spi_req is never high outside ISSUE.
// STRUCTURE
//  mem_pkg:
//   typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} arb_state_t
//   typedef enum logic {GRANT_I, GRANT_D} grant_t
//   localparams FLASH_ADDR_W=20, WORD_W=32
//  Single module, no sub-modules:
//   one always_ff for state, grant, addr, data, timer and err
//   one always_comb for outputs and next state
// TESTING
//  1 icache_miss=1, addr 0x00123; SPI ready 10 cycles after spi_req, data 0xDEADBEEF
//    -> spi_req at t+1, spi_addr=0x00123, icache_fetch 1 cycle with refill_data=0xDEADBEEF,
//       dcache_fetch stays 0.
//  2 After reset, both miss together (I 0x00040, D 0xAF010)
//    -> first spi_addr=0xAF010 with dcache_fetch; then 0x00040 with icache_fetch.
//  3 Both misses held for 4 refills -> grant order D,I,D,I. stall=1 throughout.
//  4 TIMEOUT=16, no ready -> timeout_err rises after 16 WAIT cycles, no fetch, spi_req re-issued.
//    err_clr pulsed on the next timeout edge -> timeout_err stays 1.
//    err_clr alone later -> 0.
//  5 RST_N low during WAIT -> all outputs 0 asynchronously.
//    spi_data_ready pulse after release, with no miss -> no fetch.
//  6 dcache_miss drops during WAIT, ready arrives -> dcache_fetch stays 0, FSM returns to IDLE.

Source files
------------

// File: rtl/refill_arbiter_pkg.sv
// refill_arbiter_pkg: shared types and widths for the refill arbiter
package refill_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;
  localparam int FLASH_ADDR_W = 20;
  localparam int WORD_W = 32;
endpackage

// File: rtl/refill_arbiter.sv
// refill_arbiter: shares one SPI flash reader between L1I and L1D refills
module refill_arbiter
  import refill_arbiter_pkg::*;
#(
  parameter int ADDR_W = FLASH_ADDR_W,
  parameter int DATA_W = WORD_W,
  parameter int TIMEOUT = 4096
) (
  input  logic              CLK_CPU,
  input  logic              RST_N,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_addr,
  output logic              spi_req,
  output logic [ADDR_W-1:0] spi_addr,
  input  logic              spi_data_ready,
  input  logic [DATA_W-1:0] spi_data,
  output logic              icache_fetch,
  output logic              dcache_fetch,
  output logic [DATA_W-1:0] refill_data,
  output logic              stall,
  output logic              timeout_err,
  input  logic              err_clr
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  arb_state_t state, state_nxt;
  grant_t grant, grant_nxt;
  logic [TW-1:0] timer;
  logic aborted, any_miss, tmo;
  // grant doubles as last_grant: it is only ever rewritten on a new grant
  always_comb begin
    any_miss = icache_miss | dcache_miss;
    tmo = state == ARB_WAIT && !spi_data_ready && timer == T_LAST;
    grant_nxt = (icache_miss && dcache_miss) ? (grant == GRANT_I ? GRANT_D : GRANT_I)
              : (dcache_miss ? GRANT_D : GRANT_I);
    state_nxt = state == ARB_IDLE  ? (any_miss ? ARB_ISSUE : ARB_IDLE)
              : state == ARB_ISSUE ? ARB_WAIT
              : state == ARB_WAIT  ? ((spi_data_ready || tmo) ? ARB_DONE : ARB_WAIT)
              : ARB_IDLE;
    spi_req = state == ARB_ISSUE;
    icache_fetch = state == ARB_DONE && !aborted && grant == GRANT_I && icache_miss;
    dcache_fetch = state == ARB_DONE && !aborted && grant == GRANT_D && dcache_miss;
    stall = any_miss || state != ARB_IDLE;
  end
  always_ff @(posedge CLK_CPU or negedge RST_N) begin
    if (!RST_N) begin
      state <= ARB_IDLE;
      grant <= GRANT_I;
      spi_addr <= '0;
      refill_data <= '0;
      timer <= '0;
      aborted <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && any_miss) begin
        grant <= grant_nxt;
        spi_addr <= grant_nxt == GRANT_D ? dcache_addr : icache_addr;
        aborted <= 1'b0;
      end
      if (state == ARB_ISSUE) timer <= '0;
      if (state == ARB_WAIT && spi_data_ready) refill_data <= spi_data;
      if (state == ARB_WAIT && !spi_data_ready && timer != T_LAST) timer <= timer + 1'b1;
      if (tmo) aborted <= 1'b1;
      timeout_err <= tmo | (timeout_err & ~err_clr);
    end
  end
endmodule

// File: tb/tb_refill_arbiter.sv
// tb_refill_arbiter: scenario and randomized checks of refill_arbiter against a transaction model
module tb_refill_arbiter;
  logic CLK_CPU = 1'b0, RST_N = 1'b0;
  logic icache_miss = 1'b0, dcache_miss = 1'b0;
  logic [19:0] icache_addr = '0, dcache_addr = '0;
  logic spi_req, spi_data_ready = 1'b0, err_clr = 1'b0;
  logic [19:0] spi_addr;
  logic [31:0] spi_data = '0, refill_data;
  logic icache_fetch, dcache_fetch, stall, timeout_err;
  int total = 0, bad = 0;
  bit last_d = 1'b0;

  refill_arbiter #(.ADDR_W(20), .DATA_W(32), .TIMEOUT(16)) dut (
    .CLK_CPU(CLK_CPU), .RST_N(RST_N),
    .icache_miss(icache_miss), .icache_addr(icache_addr),
    .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
    .spi_req(spi_req), .spi_addr(spi_addr),
    .spi_data_ready(spi_data_ready), .spi_data(spi_data),
    .icache_fetch(icache_fetch), .dcache_fetch(dcache_fetch),
    .refill_data(refill_data), .stall(stall),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 CLK_CPU = ~CLK_CPU;

  task automatic wait_req(output int n);
    n = 0;
    do begin
      @(negedge CLK_CPU);
      n++;
    end while (!spi_req && n < 40);
  endtask

  task automatic serve(input int dly, input logic [31:0] d, output logic [1:0] f, output logic [31:0] rd);
    repeat (dly) @(negedge CLK_CPU);
    spi_data_ready = 1'b1;
    spi_data = d;
    @(negedge CLK_CPU);
    spi_data_ready = 1'b0;
    spi_data = $urandom;
    f = {icache_fetch, dcache_fetch};
    rd = refill_data;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK_CPU);
    total++;
    if ({spi_req, icache_fetch, dcache_fetch, timeout_err, stall, spi_addr, refill_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got req=%b f=%b%b err=%b stall=%b addr=%h data=%h want all 0",
               spi_req, icache_fetch, dcache_fetch, timeout_err, stall, spi_addr, refill_data);
    end
    RST_N = 1'b1;
    last_d = 1'b0;
    @(negedge CLK_CPU);
    total++;
    if ({spi_req, stall} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset got req=%b stall=%b want 0 0", spi_req, stall);
    end
  endtask

  task automatic test_single;
    int n;
    logic [1:0] f;
    logic [31:0] rd;
    icache_addr = 20'h00123;
    dcache_addr = 20'($urandom);
    icache_miss = 1'b1;
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL single_stall_comb got %b want 1", stall); end
    wait_req(n);
    total++;
    if (n !== 1) begin bad++; $display("FAIL single_req_latency got %0d want 1", n); end
    total++;
    if (spi_addr !== 20'h00123) begin bad++; $display("FAIL single_addr got %h want 00123", spi_addr); end
    serve(10, 32'hDEADBEEF, f, rd);
    total++;
    if (f !== 2'b10) begin bad++; $display("FAIL single_fetch got %b want 10", f); end
    total++;
    if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got %h want deadbeef", rd); end
    total++;
    if (spi_addr !== 20'h00123) begin bad++; $display("FAIL single_addr_hold got %h want 00123", spi_addr); end
    last_d = 1'b0;
    @(negedge CLK_CPU);
    total++;
    if ({icache_fetch, dcache_fetch, spi_req, stall} !== 4'b0001) begin
      bad++;
      $display("FAIL single_one_pulse got f=%b%b req=%b stall=%b want 0 0 0 1", icache_fetch, dcache_fetch, spi_req, stall);
    end
    icache_miss = 1'b0;
    @(negedge CLK_CPU);
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL single_stall_release got %b want 0", stall); end
  endtask

  task automatic test_alternate;
    int n;
    bit exp_d;
    logic [1:0] f;
    logic [31:0] rd, d;
    RST_N = 1'b0;
    test_reset;
    icache_addr = 20'h00040;
    dcache_addr = 20'hAF010;
    icache_miss = 1'b1;
    dcache_miss = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = !last_d;
      wait_req(n);
      total++;
      if (n !== (k == 0 ? 1 : 2)) begin bad++; $display("FAIL alt_latency[%0d] got %0d want %0d", k, n, k == 0 ? 1 : 2); end
      total++;
      if (spi_addr !== (exp_d ? 20'hAF010 : 20'h00040)) begin
        bad++;
        $display("FAIL alt_addr[%0d] got %h want %h", k, spi_addr, exp_d ? 20'hAF010 : 20'h00040);
      end
      d = $urandom;
      serve($urandom_range(1, 8), d, f, rd);
      total++;
      if (f !== (exp_d ? 2'b01 : 2'b10)) begin bad++; $display("FAIL alt_fetch[%0d] got %b want %b", k, f, exp_d ? 2'b01 : 2'b10); end
      total++;
      if ({rd, stall} !== {d, 1'b1}) begin bad++; $display("FAIL alt_data_stall[%0d] got %h/%b want %h/1", k, rd, stall, d); end
      last_d = exp_d;
    end
    icache_miss = 1'b0;
    dcache_miss = 1'b0;
    @(negedge CLK_CPU);
  endtask

  task automatic test_timeout;
    int n;
    logic [1:0] f;
    logic [31:0] rd;
    icache_addr = 20'($urandom);
    icache_miss = 1'b1;
    wait_req(n);
    total++;
    if (n !== 1) begin bad++; $display("FAIL tmo_req_latency got %0d want 1", n); end
    repeat (16) @(negedge CLK_CPU);
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_early got %b want 0", timeout_err); end
    @(negedge CLK_CPU);
    total++;
    if ({timeout_err, icache_fetch, dcache_fetch} !== 3'b100) begin
      bad++;
      $display("FAIL tmo_set got err=%b f=%b%b want 1 0 0", timeout_err, icache_fetch, dcache_fetch);
    end
    wait_req(n);
    total++;
    if (n !== 2 || spi_addr !== icache_addr) begin bad++; $display("FAIL tmo_retry got n=%0d addr=%h want 2 %h", n, spi_addr, icache_addr); end
    repeat (16) @(negedge CLK_CPU);
    err_clr = 1'b1;
    @(negedge CLK_CPU);
    err_clr = 1'b0;
    total++;
    if ({timeout_err, icache_fetch} !== 2'b10) begin bad++; $display("FAIL tmo_set_wins got err=%b f=%b want 1 0", timeout_err, icache_fetch); end
    wait_req(n);
    serve(3, 32'h5A5A_1234, f, rd);
    total++;
    if ({f, rd} !== {2'b10, 32'h5A5A_1234}) begin bad++; $display("FAIL tmo_retry_fetch got %b/%h want 10/5a5a1234", f, rd); end
    icache_miss = 1'b0;
    @(negedge CLK_CPU);
    total++;
    if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got %b want 1", timeout_err); end
    err_clr = 1'b1;
    @(negedge CLK_CPU);
    err_clr = 1'b0;
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_clear got %b want 0", timeout_err); end
  endtask

  task automatic test_reset_mid;
    int n;
    dcache_addr = 20'h3C0DE;
    dcache_miss = 1'b1;
    wait_req(n);
    repeat (3) @(negedge CLK_CPU);
    #2;
    RST_N = 1'b0;
    dcache_miss = 1'b0;
    #1;
    total++;
    if ({spi_req, icache_fetch, dcache_fetch, timeout_err, stall, spi_addr, refill_data} !== '0) begin
      bad++;
      $display("FAIL async_reset got req=%b f=%b%b err=%b stall=%b addr=%h data=%h want all 0",
               spi_req, icache_fetch, dcache_fetch, timeout_err, stall, spi_addr, refill_data);
    end
    @(negedge CLK_CPU);
    RST_N = 1'b1;
    last_d = 1'b0;
    @(negedge CLK_CPU);
    spi_data_ready = 1'b1;
    spi_data = 32'hCAFEF00D;
    @(negedge CLK_CPU);
    spi_data_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({icache_fetch, dcache_fetch, spi_req, stall, refill_data} !== '0) begin
        bad++;
        $display("FAIL stray_ready[%0d] got f=%b%b req=%b stall=%b data=%h want all 0",
                 k, icache_fetch, dcache_fetch, spi_req, stall, refill_data);
      end
      @(negedge CLK_CPU);
    end
  endtask

  task automatic test_flush;
    int n;
    logic [1:0] f;
    logic [31:0] rd;
    dcache_addr = 20'($urandom);
    dcache_miss = 1'b1;
    wait_req(n);
    total++;
    if (n !== 1 || spi_addr !== dcache_addr) begin bad++; $display("FAIL flush_req got n=%0d addr=%h want 1 %h", n, spi_addr, dcache_addr); end
    @(negedge CLK_CPU);
    dcache_miss = 1'b0;
    serve(3, 32'h0BAD_F00D, f, rd);
    last_d = 1'b1;
    total++;
    if ({f, stall} !== 3'b001) begin bad++; $display("FAIL flush_no_fetch got f=%b stall=%b want 00 1", f, stall); end
    @(negedge CLK_CPU);
    total++;
    if ({stall, spi_req} !== 2'b00) begin bad++; $display("FAIL flush_idle got stall=%b req=%b want 0 0", stall, spi_req); end
  endtask

  task automatic test_random;
    int n;
    bit exp_d;
    logic [1:0] r, f;
    logic [31:0] rd, d;
    for (int k = 0; k < 24; k++) begin
      r = 2'($urandom_range(1, 3));
      icache_addr = 20'($urandom);
      dcache_addr = 20'($urandom);
      icache_miss = r[0];
      dcache_miss = r[1];
      exp_d = r[1] && (!r[0] || !last_d);
      wait_req(n);
      total++;
      if (n !== 1) begin bad++; $display("FAIL rnd_latency[%0d] got %0d want 1", k, n); end
      total++;
      if (spi_addr !== (exp_d ? dcache_addr : icache_addr)) begin
        bad++;
        $display("FAIL rnd_addr[%0d] got %h want %h", k, spi_addr, exp_d ? dcache_addr : icache_addr);
      end
      d = $urandom;
      serve($urandom_range(1, 14), d, f, rd);
      total++;
      if ({f, rd} !== {(exp_d ? 2'b01 : 2'b10), d}) begin
        bad++;
        $display("FAIL rnd_fetch[%0d] got %b/%h want %b/%h", k, f, rd, exp_d ? 2'b01 : 2'b10, d);
      end
      last_d = exp_d;
      icache_miss = 1'b0;
      dcache_miss = 1'b0;
      @(negedge CLK_CPU);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_alternate;
    test_timeout;
    test_reset_mid;
    test_flush;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
